// File: rtl/dot_accum.sv
// dot_accum: accumulates a configured-length run of unsigned products
// (one per prod_valid strobe) into a saturating accumulator and presents
// the dot-product result on a valid/ready port. Products are never stalled.
module dot_accum #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_sat,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               sat_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [ACC_W-1:0]   res_data_reg;
    logic               res_sat_reg;
    logic               overrun_reg;
    logic               cfg_ready_reg;
    logic               res_valid_reg;

    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   acc_next;
    logic               sat_next;

    // Add the incoming product one bit wider than the accumulator; a carry
    // out clamps to all-ones. Once clamped, every further nonzero product
    // carries again, so the accumulator stays pinned for the rest of the run.
    always_comb begin
        sum      = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
        acc_next = sum[ACC_W-1:0];
        sat_next = sat_reg;
        if (sum[ACC_W]) begin
            acc_next = '1;
            sat_next = 1'b1;
        end
    end

    // Control FSM with registered handshake outputs and result/overrun state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            cnt_reg       <= '0;
            res_data_reg  <= '0;
            res_sat_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
            cfg_ready_reg <= 1'b1;
            res_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_valid) begin
                        // Handshake clear beats a coincident stray product.
                        overrun_reg   <= 1'b0;
                        cfg_ready_reg <= 1'b0;
                        if (cfg_len != '0) begin
                            acc_reg   <= '0;
                            sat_reg   <= 1'b0;
                            cnt_reg   <= cfg_len;
                            state_reg <= ACCUM;
                        end else begin
                            res_data_reg  <= '0;
                            res_sat_reg   <= 1'b0;
                            res_valid_reg <= 1'b1;
                            state_reg     <= OUT;
                        end
                    end else if (prod_valid) begin
                        overrun_reg <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_reg <= acc_next;
                        sat_reg <= sat_next;
                        cnt_reg <= cnt_reg - LEN_W'(1);
                        if (cnt_reg == LEN_W'(1)) begin
                            res_data_reg  <= acc_next;
                            res_sat_reg   <= sat_next;
                            res_valid_reg <= 1'b1;
                            state_reg     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (prod_valid) begin
                        overrun_reg <= 1'b1;
                    end
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        cfg_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_ready_reg <= 1'b1;
                    res_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_sat   = res_sat_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: drives two dot_accum builds (ACC_W=32 and ACC_W=17) with
// the same stimulus and checks every cycle against a run-level model
// (sum of the run's products, clamped to the accumulator range).
module tb_dot_accum;

    localparam logic [63:0] MAX_A = 64'hFFFF_FFFF;
    localparam logic [63:0] MAX_B = 64'h1_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic [15:0] prod_in = 16'd0;
    logic        prod_valid = 1'b0;
    logic        res_ready = 1'b0;

    logic        cfg_ready_a, res_valid_a, res_sat_a, overrun_a;
    logic [31:0] res_data_a;
    logic        cfg_ready_b, res_valid_b, res_sat_b, overrun_b;
    logic [16:0] res_data_b;

    dot_accum #(.PROD_W(16), .ACC_W(32), .LEN_W(8)) u_a (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
        .cfg_len(cfg_len), .prod_in(prod_in), .prod_valid(prod_valid),
        .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
        .res_sat(res_sat_a), .overrun(overrun_a)
    );

    dot_accum #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) u_b (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
        .cfg_len(cfg_len), .prod_in(prod_in), .prod_valid(prod_valid),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
        .res_sat(res_sat_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    // Counters (written only by the compare process).
    int tests = 0;
    int fails = 0;

    // Hand-computed expectations for directed runs (written by the driver).
    logic [63:0] lit_a  [0:15];
    logic        lit_sa [0:15];
    logic [63:0] lit_b  [0:15];
    logic        lit_sb [0:15];
    int          lit_wr = 0;
    int          lit_rd = 0;
    bit          timeout_hit = 1'b0;
    bit          drv_done = 1'b0;
    bit          final_done = 1'b0;

    // Run-level model: 0 = idle, 1 = collecting products, 2 = result held.
    int          m_mode = 0;
    int          m_need = 0;
    int          m_got = 0;
    logic [63:0] m_sum = 0;
    logic [63:0] m_res_a = 0;
    logic [63:0] m_res_b = 0;
    bit          m_sat_a = 0;
    bit          m_sat_b = 0;
    bit          m_ovr = 0;
    bit          m_live = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Compare process: on every falling edge check both DUTs against the
    // model, then advance the model with the inputs the next rising edge sees.
    initial begin
        bit to_seen = 0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("a_cfg_ready", cfg_ready_a, m_mode == 0);
                chk("a_res_valid", res_valid_a, m_mode == 2);
                chk("a_res_data",  res_data_a,  m_res_a);
                chk("a_res_sat",   res_sat_a,   m_sat_a);
                chk("a_overrun",   overrun_a,   m_ovr);
                chk("b_cfg_ready", cfg_ready_b, m_mode == 0);
                chk("b_res_valid", res_valid_b, m_mode == 2);
                chk("b_res_data",  res_data_b,  m_res_b);
                chk("b_res_sat",   res_sat_b,   m_sat_b);
                chk("b_overrun",   overrun_b,   m_ovr);
            end
            if (timeout_hit && !to_seen) begin
                to_seen = 1;
                chk("timeout", 1, 0);
            end
            if (m_live && !rst && m_mode == 2 && res_ready && lit_rd < lit_wr) begin
                chk("lit_a_data", res_data_a, lit_a[lit_rd]);
                chk("lit_a_sat",  res_sat_a,  lit_sa[lit_rd]);
                chk("lit_b_data", res_data_b, lit_b[lit_rd]);
                chk("lit_b_sat",  res_sat_b,  lit_sb[lit_rd]);
                lit_rd++;
            end
            if (drv_done && !final_done) begin
                chk("lit_results_seen", lit_rd, lit_wr);
                final_done = 1;
            end
            if (rst) begin
                m_live = 1; m_mode = 0; m_need = 0; m_got = 0; m_sum = 0;
                m_res_a = 0; m_res_b = 0; m_sat_a = 0; m_sat_b = 0; m_ovr = 0;
            end else if (m_live) begin
                if (m_mode == 0) begin
                    if (cfg_valid) begin
                        m_ovr = 0;
                        if (cfg_len == 0) begin
                            m_res_a = 0; m_res_b = 0; m_sat_a = 0; m_sat_b = 0;
                            m_mode = 2;
                        end else begin
                            m_need = int'(cfg_len); m_got = 0; m_sum = 0;
                            m_mode = 1;
                        end
                    end else if (prod_valid) begin
                        m_ovr = 1;
                    end
                end else if (m_mode == 1) begin
                    if (prod_valid) begin
                        m_sum = m_sum + 64'(prod_in);
                        m_got++;
                        if (m_got == m_need) begin
                            // Partial sums only grow, so clamping the total
                            // is equivalent to clamping at every step.
                            m_sat_a = m_sum > MAX_A;
                            m_res_a = m_sat_a ? MAX_A : m_sum;
                            m_sat_b = m_sum > MAX_B;
                            m_res_b = m_sat_b ? MAX_B : m_sum;
                            m_mode = 2;
                        end
                    end
                end else begin
                    if (prod_valid) m_ovr = 1;
                    if (res_ready) m_mode = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input logic [63:0] a, input bit sa, input logic [63:0] b, input bit sb);
        lit_a[lit_wr] = a; lit_sa[lit_wr] = sa;
        lit_b[lit_wr] = b; lit_sb[lit_wr] = sb;
        lit_wr++;
    endtask

    task automatic cfg(input int len, input bit stray);
        int n = 0;
        while (!cfg_ready_a && n < 400) begin tick; n++; end
        if (!cfg_ready_a) timeout_hit = 1'b1;
        cfg_valid = 1'b1; cfg_len = len[7:0];
        prod_valid = stray; prod_in = 16'h5A5A;
        tick;
        cfg_valid = 1'b0; prod_valid = 1'b0;
    endtask

    task automatic prod(input int v, input int gap, input bit noise);
        repeat (gap) begin
            cfg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick;
        end
        cfg_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        prod_in = v[15:0]; prod_valid = 1'b1;
        tick;
        prod_valid = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic take(input int stall, input bit noise);
        int n = 0;
        while (!res_valid_a && n < 400) begin tick; n++; end
        if (!res_valid_a) timeout_hit = 1'b1;
        repeat (stall) begin
            if (noise) begin
                cfg_valid = 1'($urandom_range(0, 1));
                prod_valid = 1'($urandom_range(0, 1));
                prod_in = 16'($urandom);
            end
            tick;
        end
        cfg_valid = 1'b0; prod_valid = 1'b0;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;

        // Back-to-back run of four products: 3+5+7+9.
        expect_lit(24, 0, 24, 0);
        cfg(4, 0);
        prod(3, 0, 0); prod(5, 0, 0); prod(7, 0, 0); prod(9, 0, 0);
        take(0, 0);

        // Gapped products and a stalled consumer.
        expect_lit(600, 0, 600, 0);
        cfg(3, 0);
        prod(100, 2, 0); prod(200, 0, 0); prod(300, 3, 0);
        take(5, 0);

        // Reaching all-ones exactly without a carry is not saturation.
        expect_lit(64'h1FFFF, 0, 64'h1FFFF, 0);
        cfg(3, 0);
        prod(16'hFFFF, 0, 0); prod(16'hFFFF, 0, 0); prod(1, 0, 0);
        take(0, 0);

        // One more unit carries out of the 17-bit accumulator.
        expect_lit(64'h20000, 0, 64'h1FFFF, 1);
        cfg(3, 0);
        prod(16'hFFFF, 0, 0); prod(16'hFFFF, 0, 0); prod(2, 0, 0);
        take(1, 0);

        // Saturation flag does not leak into the next run.
        expect_lit(3, 0, 3, 0);
        cfg(2, 0);
        prod(2, 0, 0); prod(1, 0, 0);
        take(0, 0);

        // Zero-length run.
        expect_lit(0, 0, 0, 0);
        cfg(0, 0);
        take(0, 0);

        // Stray product in IDLE sets overrun; next handshake clears it.
        prod(9, 0, 0);
        repeat (3) tick;
        expect_lit(4, 0, 4, 0);
        cfg(2, 0);
        prod(2, 0, 0); prod(2, 1, 0);
        take(0, 0);

        // Stray product coinciding with the cfg handshake: clear wins.
        prod(1, 0, 0);
        expect_lit(11, 0, 11, 0);
        cfg(1, 1);
        prod(11, 0, 0);
        take(2, 0);

        // Reset mid-run discards everything; then a fresh single-product run.
        cfg(5, 0);
        prod(1, 0, 0); prod(2, 0, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        expect_lit(7, 0, 7, 0);
        cfg(1, 0);
        prod(7, 0, 0);
        take(0, 0);

        // Maximum-length back-to-back run: 255 * 0xFFFF.
        expect_lit(64'hFEFF01, 0, 64'h1FFFF, 1);
        cfg(255, 0);
        for (int i = 0; i < 255; i++) prod(16'hFFFF, 0, 0);
        take(0, 0);

        // Randomized runs with cfg noise, stray products and consumer stalls.
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(0, 10);
            if ($urandom_range(0, 3) == 0) prod(16'($urandom), 0, 0);
            cfg(len, 1'($urandom_range(0, 4) == 0));
            for (int i = 0; i < len; i++) begin
                int v;
                v = ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535));
                prod(v, $urandom_range(0, 2), 1);
            end
            take($urandom_range(0, 4), 1);
        end

        repeat (2) tick;
        drv_done = 1'b1;
        repeat (2) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
